// File: rtl/qdec_updown.sv
// qdec_updown: quadrature decoder feeding a wrapping up/down position counter
module qdec_updown #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [1:0] r_a_sync, r_b_sync, r_prev, r_init_cnt;
  logic [1:0] w_cur, w_pos_cur, w_pos_prev, w_delta;
  logic w_load, w_run, w_up, w_dn, w_ill, w_cnt;
  logic [WIDTH-1:0] r_count;
  logic r_dir, r_step, r_err;
  assign w_cur = {r_a_sync[1], r_b_sync[1]};
  assign count = r_count;
  assign dir   = r_dir;
  assign step  = r_step;
  assign err   = r_err;
  // two-flop synchronizers for the asynchronous encoder phases
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_a_sync <= '0;
      r_b_sync <= '0;
    end else begin
      r_a_sync <= {r_a_sync[0], a_in};
      r_b_sync <= {r_b_sync[0], b_in};
    end
  // state register plus INIT edge counter that lets the synchronizers fill
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + 2'd1 : r_init_cnt;
    end
  // next state and decode: phases mapped to positions 0..3 along the up sequence
  always_comb begin
    w_load      = (r_state == S_INIT) && (r_init_cnt == 2'd2);
    w_state_nxt = w_load ? S_RUN : r_state;
    w_run       = (r_state == S_RUN);
    w_pos_cur   = {w_cur[0], ^w_cur};
    w_pos_prev  = {r_prev[0], ^r_prev};
    w_delta     = w_pos_cur - w_pos_prev;
    w_up        = w_run && (w_delta == 2'd1);
    w_dn        = w_run && (w_delta == 2'd3);
    w_ill       = w_run && (w_delta == 2'd2);
    w_cnt       = (w_up || w_dn) && en;
  end
  // prev tracks the phase state whenever decoding is live, regardless of en
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_prev <= '0;
    else if (w_load || w_run) r_prev <= w_cur;
  // position counter, direction, step pulse and sticky error flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_count <= '0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= clr ? '0 : !w_cnt ? r_count : w_up ? r_count + 1'b1 : r_count - 1'b1;
      r_dir   <= w_cnt ? w_dn : r_dir;
      r_step  <= w_cnt;
      r_err   <= w_ill ? 1'b1 : err_clr ? 1'b0 : r_err;
    end
endmodule

// File: tb/tb_qdec_updown.sv
// tb_qdec_updown: randomized quadrature stimulus checked against a sampled-history position model
module tb_qdec_updown;
  localparam int W = 8;
  localparam int M = 1 << W;
  logic clk = 0, rst = 0, a_in = 0, b_in = 0, en = 0, clr = 0, err_clr = 0;
  logic [W-1:0] count;
  logic dir, step, err;
  int checks = 0, errors = 0;
  int k, m_count, m_dir, m_step, m_err, gap;
  logic [1:0] hist[$];
  logic [1:0] ab;
  int pos_of[4] = '{0, 3, 1, 2};
  logic [1:0] ab_of[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  qdec_updown #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en), .clr(clr),
    .err_clr(err_clr), .count(count), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    hist.delete();
    hist.push_back(2'b00);
    m_count = 0; m_dir = 0; m_step = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int d;
    bit mv;
    k++;
    hist.push_back({a_in, b_in});
    d = (k >= 4) ? ((pos_of[hist[k-2]] - pos_of[hist[k-3]]) & 3) : 0;
    mv = (d == 1 || d == 3) && en;
    m_step = mv;
    if (mv) m_dir = (d == 3);
    m_count = clr ? 0 : mv ? (m_count + M + (d == 1 ? 1 : -1)) % M : m_count;
    m_err = (d == 2) ? 1 : err_clr ? 0 : m_err;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("count", count, m_count);
    chk("dir", dir, m_dir);
    chk("step", step, m_step);
    chk("err", err, m_err);
  endtask

  task automatic rand_cycle(input int up_pct);
    int r;
    if (gap >= 3 && $urandom_range(2) == 0) begin
      r = $urandom_range(99);
      ab = (r < 6) ? ab ^ 2'b11 : (r < 6 + up_pct) ? ab_of[(pos_of[ab] + 1) & 3] : ab_of[(pos_of[ab] + 3) & 3];
      gap = 0;
    end else gap++;
    {a_in, b_in} = ab;
    en = ($urandom_range(7) != 0);
    clr = ($urandom_range(63) == 0);
    err_clr = ($urandom_range(15) == 0);
    cycle();
  endtask

  initial begin
    model_reset();
    a_in = 1; b_in = 1; en = 1;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_step", step, 0);
    rst = 1;
    repeat (6) cycle();
    chk("init_no_err", err, 0);
    ab = 2'b11;
    gap = 0;
    repeat (1500) rand_cycle(70);
    #2 rst = 0;
    #1;
    chk("async_count", count, 0);
    chk("async_err", err, 0);
    chk("async_dir", dir, 0);
    chk("async_step", step, 0);
    model_reset();
    ab = {a_in, b_in};
    gap = 0;
    #1 rst = 1;
    repeat (1500) rand_cycle(24);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
